// File: rtl/add_tree_pkg.sv
// Shared types and constants for the add_tree_64 round-robin scheduler.
package add_tree_pkg;

  localparam int DW       = 16;
  localparam int VEC_W    = 64 * DW;
  localparam int TREE_LAT = 12;

  typedef enum logic [3:0] {
    LEN64 = 4'd0,
    LEN32 = 4'd1,
    LEN16 = 4'd2
  } len_mode_e;

  typedef struct packed {
    logic       id;
    logic [3:0] mode;
  } tag_t;

  // Number of valid sums a length mode produces; 0 flags an illegal mode.
  function automatic logic [2:0] mode_cnt(input logic [3:0] mode);
    case (mode)
      LEN64:   mode_cnt = 3'd1;
      LEN32:   mode_cnt = 3'd2;
      LEN16:   mode_cnt = 3'd4;
      default: mode_cnt = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/add_tree_tag_fifo.sv
// Tag FIFO tracking in-flight tree operations in issue order.
// Push and pop may happen in the same cycle; the count is then unchanged.
module add_tree_tag_fifo
  import add_tree_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_push,
  input  tag_t i_tag,
  input  logic i_pop,
  output tag_t o_tag,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  tag_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push_ok;
  logic          pop_ok;

  assign o_full  = (count == CW'(DEPTH));
  assign o_empty = (count == '0);
  assign push_ok = i_push & ~o_full;
  assign pop_ok  = i_pop & ~o_empty;
  assign o_tag   = mem[rd_ptr];

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= i_tag;
  end

  // Pointer and occupancy tracking, wrapping at DEPTH.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/add_tree_sched.sv
// Round-robin scheduler sharing one add_tree_64 between two requesters.
// Optional macro ADD_TREE_SCHED_STATS_EN adds saturating issue/stall counters.
module add_tree_sched #(
  parameter int TREE_LAT  = add_tree_pkg::TREE_LAT,
  parameter int TAG_DEPTH = 16,
  parameter int DW        = add_tree_pkg::DW
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [3:0]       i_req0_mode,
  input  logic [64*DW-1:0] i_req0_data,
  input  logic [64*DW-1:0] i_req0_byp,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [3:0]       i_req1_mode,
  input  logic [64*DW-1:0] i_req1_data,
  input  logic [64*DW-1:0] i_req1_byp,
  output logic             o_tree_en,
  output logic             o_tree_valid,
  output logic [3:0]       o_tree_mode,
  output logic [64*DW-1:0] o_tree_in1,
  output logic [64*DW-1:0] o_tree_in0,
  input  logic [31:0]      i_tree_sum64_0,
  input  logic [31:0]      i_tree_sum32_0,
  input  logic [31:0]      i_tree_sum32_1,
  input  logic [31:0]      i_tree_sum16_0,
  input  logic [31:0]      i_tree_sum16_1,
  input  logic [31:0]      i_tree_sum16_2,
  input  logic [31:0]      i_tree_sum16_3,
  input  logic             i_tree_valid_byp,
  input  logic [3:0]       i_tree_mode_byp,
  input  logic [64*DW-1:0] i_tree_in0_byp,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic             o_res_id,
  output logic [3:0]       o_res_mode,
  output logic [2:0]       o_res_cnt,
  output logic [31:0]      o_res_sum0,
  output logic [31:0]      o_res_sum1,
  output logic [31:0]      o_res_sum2,
  output logic [31:0]      o_res_sum3,
  output logic [64*DW-1:0] o_res_byp,
  output logic             o_res_err,
  output logic             o_err_seq
`ifdef ADD_TREE_SCHED_STATS_EN
  ,
  output logic [31:0]      o_stat_iss0,
  output logic [31:0]      o_stat_iss1,
  output logic [31:0]      o_stat_stall
`endif
);

  import add_tree_pkg::*;

  // The tag FIFO must cover every slot of the tree plus the output register.
  localparam int FIFO_DEPTH = (TAG_DEPTH >= TREE_LAT + 1) ? TAG_DEPTH : TREE_LAT + 1;

  logic        rr_ptr;
  logic        grant0;
  logic        grant1;
  logic        accept;
  logic        fifo_full;
  logic        fifo_empty;
  logic        cap;
  logic        pop;
  tag_t        push_tag;
  tag_t        pop_tag;
  logic [31:0] nxt_sum [4];
  logic        nxt_err;

  assign o_tree_en    = ~(o_res_valid & ~i_res_ready);
  assign grant0       = i_req0_valid & (~i_req1_valid | ~rr_ptr);
  assign grant1       = i_req1_valid & (~i_req0_valid | rr_ptr);
  assign o_req0_ready = grant0 & o_tree_en & ~fifo_full;
  assign o_req1_ready = grant1 & o_tree_en & ~fifo_full;
  assign accept       = (i_req0_valid & o_req0_ready) | (i_req1_valid & o_req1_ready);
  assign o_tree_valid = accept;
  assign push_tag     = {grant1, o_tree_mode};
  assign cap          = i_tree_valid_byp & o_tree_en;
  assign pop          = cap & ~fifo_empty;

  // Route the granted requester's vectors into the tree; idle inputs are zero.
  always_comb begin
    o_tree_mode = '0;
    o_tree_in1  = '0;
    o_tree_in0  = '0;
    if (grant0) begin
      o_tree_mode = i_req0_mode;
      o_tree_in1  = i_req0_data;
      o_tree_in0  = i_req0_byp;
    end else if (grant1) begin
      o_tree_mode = i_req1_mode;
      o_tree_in1  = i_req1_data;
      o_tree_in0  = i_req1_byp;
    end
  end

  add_tree_tag_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_tag_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (accept),
    .i_tag   (push_tag),
    .i_pop   (pop),
    .o_tag   (pop_tag),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  // Pack the tree sums into lanes according to the mode recorded at issue.
  always_comb begin
    nxt_sum[0] = '0;
    nxt_sum[1] = '0;
    nxt_sum[2] = '0;
    nxt_sum[3] = '0;
    nxt_err    = 1'b0;
    case (pop_tag.mode)
      LEN64: nxt_sum[0] = i_tree_sum64_0;
      LEN32: begin
        nxt_sum[0] = i_tree_sum32_0;
        nxt_sum[1] = i_tree_sum32_1;
      end
      LEN16: begin
        nxt_sum[0] = i_tree_sum16_0;
        nxt_sum[1] = i_tree_sum16_1;
        nxt_sum[2] = i_tree_sum16_2;
        nxt_sum[3] = i_tree_sum16_3;
      end
      default: nxt_err = 1'b1;
    endcase
  end

  // Result register: a capture wins over a drain so back-to-back results flow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_res_valid <= 1'b0;
      o_res_id    <= 1'b0;
      o_res_mode  <= '0;
      o_res_cnt   <= '0;
      o_res_sum0  <= '0;
      o_res_sum1  <= '0;
      o_res_sum2  <= '0;
      o_res_sum3  <= '0;
      o_res_byp   <= '0;
      o_res_err   <= 1'b0;
    end else if (pop) begin
      o_res_valid <= 1'b1;
      o_res_id    <= pop_tag.id;
      o_res_mode  <= pop_tag.mode;
      o_res_cnt   <= mode_cnt(pop_tag.mode);
      o_res_sum0  <= nxt_sum[0];
      o_res_sum1  <= nxt_sum[1];
      o_res_sum2  <= nxt_sum[2];
      o_res_sum3  <= nxt_sum[3];
      o_res_byp   <= i_tree_in0_byp;
      o_res_err   <= nxt_err;
    end else if (i_res_ready) begin
      o_res_valid <= 1'b0;
    end
  end

  // Sticky flag for tree results with no matching tag or a mismatched mode.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err_seq <= 1'b0;
    end else if ((cap & fifo_empty) | (pop & (pop_tag.mode != i_tree_mode_byp))) begin
      o_err_seq <= 1'b1;
    end
  end

  // Round-robin pointer hands priority to the other requester after each accept.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr <= 1'b0;
    end else if (accept) begin
      rr_ptr <= grant0;
    end
  end

`ifdef ADD_TREE_SCHED_STATS_EN
  // Saturating counters for per-requester issues and tree stall cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stat_iss0  <= '0;
      o_stat_iss1  <= '0;
      o_stat_stall <= '0;
    end else begin
      if (accept & grant0 & (o_stat_iss0 != '1))  o_stat_iss0  <= o_stat_iss0 + 1'b1;
      if (accept & grant1 & (o_stat_iss1 != '1))  o_stat_iss1  <= o_stat_iss1 + 1'b1;
      if (~o_tree_en & (o_stat_stall != '1))      o_stat_stall <= o_stat_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_add_tree_sched.sv
// Self-checking bench for add_tree_sched with a behavioural add_tree_64 model
// and a scoreboard of expected results in accept order.
module tb_add_tree_sched;
  import add_tree_pkg::*;

  localparam int TL = TREE_LAT;
  typedef logic [VEC_W-1:0] vec_t;

  typedef struct packed {
    logic        id;
    logic [3:0]  mode;
    logic [2:0]  cnt;
    logic [31:0] s0;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] s3;
    logic [63:0] bypf;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic        v;
    logic [3:0]  mode;
    logic [31:0] s64;
    logic [31:0] s32a;
    logic [31:0] s32b;
    logic [31:0] s16a;
    logic [31:0] s16b;
    logic [31:0] s16c;
    logic [31:0] s16d;
    vec_t        byp;
  } tstage_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_req0_valid, o_req0_ready, i_req1_valid, o_req1_ready;
  logic [3:0]  i_req0_mode, i_req1_mode;
  vec_t        i_req0_data, i_req0_byp, i_req1_data, i_req1_byp;
  logic        o_tree_en, o_tree_valid;
  logic [3:0]  o_tree_mode;
  vec_t        o_tree_in1, o_tree_in0;
  logic        o_res_valid, i_res_ready, o_res_id, o_res_err, o_err_seq;
  logic [3:0]  o_res_mode;
  logic [2:0]  o_res_cnt;
  logic [31:0] o_res_sum0, o_res_sum1, o_res_sum2, o_res_sum3;
  vec_t        o_res_byp;
`ifdef ADD_TREE_SCHED_STATS_EN
  logic [31:0] o_stat_iss0, o_stat_iss1, o_stat_stall;
`endif

  tstage_t pipe [TL];
  tstage_t tin;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  int   n_acc    = 0;
  int   n_res    = 0;
  int   n_stall  = 0;
  bit   rr_model = 1'b0;
  exp_t sb [$];

  always #5 i_clk = ~i_clk;

  add_tree_sched dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_req0_valid     (i_req0_valid),
    .o_req0_ready     (o_req0_ready),
    .i_req0_mode      (i_req0_mode),
    .i_req0_data      (i_req0_data),
    .i_req0_byp       (i_req0_byp),
    .i_req1_valid     (i_req1_valid),
    .o_req1_ready     (o_req1_ready),
    .i_req1_mode      (i_req1_mode),
    .i_req1_data      (i_req1_data),
    .i_req1_byp       (i_req1_byp),
    .o_tree_en        (o_tree_en),
    .o_tree_valid     (o_tree_valid),
    .o_tree_mode      (o_tree_mode),
    .o_tree_in1       (o_tree_in1),
    .o_tree_in0       (o_tree_in0),
    .i_tree_sum64_0   (pipe[TL-1].s64),
    .i_tree_sum32_0   (pipe[TL-1].s32a),
    .i_tree_sum32_1   (pipe[TL-1].s32b),
    .i_tree_sum16_0   (pipe[TL-1].s16a),
    .i_tree_sum16_1   (pipe[TL-1].s16b),
    .i_tree_sum16_2   (pipe[TL-1].s16c),
    .i_tree_sum16_3   (pipe[TL-1].s16d),
    .i_tree_valid_byp (pipe[TL-1].v),
    .i_tree_mode_byp  (pipe[TL-1].mode),
    .i_tree_in0_byp   (pipe[TL-1].byp),
    .o_res_valid      (o_res_valid),
    .i_res_ready      (i_res_ready),
    .o_res_id         (o_res_id),
    .o_res_mode       (o_res_mode),
    .o_res_cnt        (o_res_cnt),
    .o_res_sum0       (o_res_sum0),
    .o_res_sum1       (o_res_sum1),
    .o_res_sum2       (o_res_sum2),
    .o_res_sum3       (o_res_sum3),
    .o_res_byp        (o_res_byp),
    .o_res_err        (o_res_err),
    .o_err_seq        (o_err_seq)
`ifdef ADD_TREE_SCHED_STATS_EN
    ,
    .o_stat_iss0      (o_stat_iss0),
    .o_stat_iss1      (o_stat_iss1),
    .o_stat_stall     (o_stat_stall)
`endif
  );

  function automatic logic [31:0] vsum(input vec_t d, input int lo, input int n);
    int acc = 0;
    for (int i = 0; i < n; i++) acc = acc + int'($signed(d[(lo + i)*DW +: DW]));
    return acc;
  endfunction

  function automatic logic [63:0] fold(input vec_t v);
    logic [63:0] r = '0;
    for (int i = 0; i < VEC_W/64; i++) r = r ^ v[i*64 +: 64];
    return r;
  endfunction

  function automatic vec_t fill_vec(input logic [15:0] lo_val, input logic [15:0] hi_val);
    vec_t v;
    for (int i = 0; i < 64; i++) v[i*DW +: DW] = (i < 32) ? lo_val : hi_val;
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < VEC_W/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic exp_t model(input logic id, input logic [3:0] mode, input vec_t d, input vec_t b);
    exp_t e = '0;
    e.id   = id;
    e.mode = mode;
    e.bypf = fold(b);
    case (mode)
      4'd0: begin e.cnt = 3'd1; e.s0 = vsum(d, 0, 64); end
      4'd1: begin e.cnt = 3'd2; e.s0 = vsum(d, 0, 32); e.s1 = vsum(d, 32, 32); end
      4'd2: begin
        e.cnt = 3'd4;
        e.s0 = vsum(d, 0, 16);  e.s1 = vsum(d, 16, 16);
        e.s2 = vsum(d, 32, 16); e.s3 = vsum(d, 48, 16);
      end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  // Behavioural add_tree_64 input stage: all sums of i_in1, mode and bypass.
  always_comb begin
    tin      = '0;
    tin.v    = o_tree_valid;
    tin.mode = o_tree_mode;
    tin.s64  = vsum(o_tree_in1, 0, 64);
    tin.s32a = vsum(o_tree_in1, 0, 32);
    tin.s32b = vsum(o_tree_in1, 32, 32);
    tin.s16a = vsum(o_tree_in1, 0, 16);
    tin.s16b = vsum(o_tree_in1, 16, 16);
    tin.s16c = vsum(o_tree_in1, 32, 16);
    tin.s16d = vsum(o_tree_in1, 48, 16);
    tin.byp  = o_tree_in0;
  end

  // Tree pipeline advancing only while enabled; reset alongside the scheduler.
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < TL; i++) pipe[i] <= '0;
    end else if (o_tree_en) begin
      pipe[0] <= tin;
      for (int i = 1; i < TL; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Cycle counter used for latency and throughput measurement.
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Monitor: arbitration model, stall rule, scoreboard push on accept and pop on transfer.
  always @(negedge i_clk) begin
    logic exp_en, e_r0, e_r1;
    exp_t e;
    if (!i_rst_n) begin
      sb.delete();
      rr_model = 1'b0;
    end else begin
      exp_en = !(o_res_valid && !i_res_ready);
      e_r0   = i_req0_valid && (!i_req1_valid || !rr_model) && exp_en;
      e_r1   = i_req1_valid && (!i_req0_valid || rr_model) && exp_en;
      checkOutput("tree_en", o_tree_en, exp_en);
      checkOutput("req0_ready", o_req0_ready, e_r0);
      checkOutput("req1_ready", o_req1_ready, e_r1);
      checkOutput("tree_valid", o_tree_valid, e_r0 | e_r1);
      if (!o_tree_en) n_stall++;
      if (i_req0_valid && o_req0_ready) begin
        sb.push_back(model(1'b0, i_req0_mode, i_req0_data, i_req0_byp));
        rr_model = 1'b1; n_acc++; acc_cyc = cyc;
      end else if (i_req1_valid && o_req1_ready) begin
        sb.push_back(model(1'b1, i_req1_mode, i_req1_data, i_req1_byp));
        rr_model = 1'b0; n_acc++; acc_cyc = cyc;
      end
      if (o_res_valid && i_res_ready) begin
        n_res++;
        if (sb.size() == 0) begin
          checkOutput("unexpected_result", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("res_id", o_res_id, e.id);
          checkOutput("res_mode", o_res_mode, e.mode);
          checkOutput("res_cnt", o_res_cnt, e.cnt);
          checkOutput("res_sum0", o_res_sum0, e.s0);
          checkOutput("res_sum1", o_res_sum1, e.s1);
          checkOutput("res_sum2", o_res_sum2, e.s2);
          checkOutput("res_sum3", o_res_sum3, e.s3);
          checkOutput("res_byp", fold(o_res_byp), e.bypf);
          checkOutput("res_err", o_res_err, e.err);
        end
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // Present one op on requester k and hold it until the handshake completes.
  task automatic applyStimulus(input int k, input logic [3:0] mode, input vec_t data, input vec_t byp);
    int budget = 0;
    bit done   = 1'b0;
    if (k == 0) begin
      i_req0_valid = 1'b1; i_req0_mode = mode; i_req0_data = data; i_req0_byp = byp;
    end else begin
      i_req1_valid = 1'b1; i_req1_mode = mode; i_req1_data = data; i_req1_byp = byp;
    end
    while (!done && budget < 200) begin
      @(negedge i_clk);
      if ((k == 0) ? o_req0_ready : o_req1_ready) done = 1'b1;
      @(posedge i_clk);
      #1;
      budget++;
    end
    if (!done) checkOutput("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic dropReq(input int k);
    if (k == 0) i_req0_valid = 1'b0;
    else        i_req1_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int budget = 0;
    while (sb.size() != 0 && budget < 300) begin
      waitCycles(1);
      budget++;
    end
    checkOutput("drain_left", sb.size(), 64'd0);
  endtask

  task automatic waitResValid();
    int budget = 0;
    while (!o_res_valid && budget < 100) begin
      @(negedge i_clk);
      budget++;
    end
    checkOutput("res_valid_seen", o_res_valid, 64'd1);
  endtask

  task automatic pulseReset();
    @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    checkOutput("rst_res_valid", o_res_valid, 64'd0);
    checkOutput("rst_tree_en", o_tree_en, 64'd1);
    checkOutput("rst_err_seq", o_err_seq, 64'd0);
    waitCycles(2);
    i_rst_n = 1'b1;
    waitCycles(1);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s, stall_base, res_base, lat_budget;
    i_rst_n = 1'b0; i_res_ready = 1'b1;
    i_req0_valid = 1'b0; i_req0_mode = '0; i_req0_data = '0; i_req0_byp = '0;
    i_req1_valid = 1'b0; i_req1_mode = '0; i_req1_data = '0; i_req1_byp = '0;
    waitCycles(3);
    $display("[TB] reset state");
    checkOutput("reset_res_valid", o_res_valid, 64'd0);
    checkOutput("reset_res_sum0", o_res_sum0, 64'd0);
    checkOutput("reset_res_cnt", o_res_cnt, 64'd0);
    checkOutput("reset_err_seq", o_err_seq, 64'd0);
    checkOutput("reset_tree_en", o_tree_en, 64'd1);
    checkOutput("reset_tree_valid", o_tree_valid, 64'd0);
    i_rst_n = 1'b1;
    waitCycles(2);

    $display("[TB] single op, mode 64, latency");
    applyStimulus(0, 4'd0, fill_vec(16'h0100, 16'h0100), rand_vec());
    dropReq(0);
    lat_budget = 0;
    do begin
      @(negedge i_clk);
      lat_budget++;
    end while (!o_res_valid && lat_budget < 50);
    checkOutput("latency", cyc - acc_cyc, TL + 1);
    checkOutput("single_sum0", o_res_sum0, 64'h4000);
    waitCycles(1);
    waitDrain();

    $display("[TB] round-robin contention");
    s = cyc;
    fork
      begin
        for (int b = 0; b < 4; b++) applyStimulus(0, 4'($urandom_range(0, 2)), rand_vec(), rand_vec());
        dropReq(0);
      end
      begin
        for (int b = 0; b < 4; b++) applyStimulus(1, 4'($urandom_range(0, 2)), rand_vec(), rand_vec());
        dropReq(1);
      end
    join
    checkOutput("rr_span", acc_cyc - s, 64'd7);
    waitDrain();

    $display("[TB] mode 32 with back-pressure");
    stall_base = n_stall;
    res_base   = n_res;
    fork
      begin
        for (int b = 0; b < 6; b++) applyStimulus(0, 4'd1, fill_vec(16'h0100, 16'h0200), rand_vec());
        dropReq(0);
      end
      begin
        waitCycles(16);
        i_res_ready = 1'b0;
        waitCycles(5);
        i_res_ready = 1'b1;
      end
    join
    waitDrain();
    checkOutput("bp_results", n_res - res_base, 64'd6);
    checkOutput("bp_stall_cycles", n_stall - stall_base, 64'd5);

    $display("[TB] mode 16 negative, then illegal mode");
    applyStimulus(1, 4'd2, fill_vec(16'hFF00, 16'hFF00), rand_vec());
    applyStimulus(1, 4'd3, rand_vec(), rand_vec());
    dropReq(1);
    waitDrain();

    $display("[TB] reset with ops in flight");
    i_res_ready = 1'b0;
    for (int b = 0; b < 5; b++) applyStimulus(0, 4'd0, rand_vec(), rand_vec());
    dropReq(0);
    waitResValid();
    pulseReset();
    i_res_ready = 1'b1;
    repeat (20) begin
      @(negedge i_clk);
      checkOutput("post_rst_valid", o_res_valid, 64'd0);
    end
    waitCycles(1);
    applyStimulus(0, 4'd2, rand_vec(), rand_vec());
    dropReq(0);
    waitDrain();
    checkOutput("post_rst_err_seq", o_err_seq, 64'd0);

    $display("[TB] issue and stall accounting");
    pulseReset();
    stall_base = n_stall;
    i_res_ready = 1'b0;
    fork
      begin
        for (int b = 0; b < 3; b++) applyStimulus(0, 4'd0, rand_vec(), rand_vec());
        dropReq(0);
      end
      begin
        for (int b = 0; b < 2; b++) applyStimulus(1, 4'd1, rand_vec(), rand_vec());
        dropReq(1);
      end
    join
    waitResValid();
    repeat (4) @(posedge i_clk);
    #1 i_res_ready = 1'b1;
    waitDrain();
    checkOutput("stat_stall_seen", n_stall - stall_base, 64'd4);
`ifdef ADD_TREE_SCHED_STATS_EN
    checkOutput("stat_iss0", o_stat_iss0, 64'd3);
    checkOutput("stat_iss1", o_stat_iss1, 64'd2);
    checkOutput("stat_stall", o_stat_stall, 64'd4);
`endif

    checkOutput("final_err_seq", o_err_seq, 64'd0);
    checkOutput("final_sb_empty", sb.size(), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/add_tree_sched.md
Name: add_tree_sched

Overview:
- Round-robin scheduler sharing one add_tree_64 instance between two requesters (e.g. softmax exponent-sum lanes).
- Issues one vector per cycle into the tree and tracks in-flight ops in a tag FIFO. Routes each result, with requester ID and lane-packed sums, to a single ready/valid result port.
- Stalls the whole tree through its i_en when the result consumer back-pressures.

Parameters:
- TREE_LAT, 12, add_tree_64 input-to-o_valid_byp latency in enabled cycles.
- TAG_DEPTH, 16, tag FIFO depth; must be >= TREE_LAT+1.
- DW, 16, element width (Q6.10); vector = 64*DW bits.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset. The top ties the tree's i_rst to ~i_rst_n.
- i_req0_valid / o_req0_ready  in/out  1  requester 0 handshake.
- i_req0_mode  in  4  length mode: 0 = 64, 1 = 32, 2 = 16.
- i_req0_data  in  64*DW  summation vector.
- i_req0_byp  in  64*DW  bypass vector.
- i_req1_valid, o_req1_ready, i_req1_mode, i_req1_data, i_req1_byp: same as requester 0.
- o_tree_en  out  1  drives tree i_en.
- o_tree_valid  out  1  drives tree i_valid.
- o_tree_mode  out  4  drives tree i_length_mode.
- o_tree_in1  out  64*DW  drives tree i_in1_flat.
- o_tree_in0  out  64*DW  drives tree i_in0_flat.
- i_tree_sum64_0, i_tree_sum32_0..1, i_tree_sum16_0..3  in  32 each  tree sums.
- i_tree_valid_byp  in  1  tree output valid.
- i_tree_mode_byp  in  4  tree output length mode.
- i_tree_in0_byp  in  64*DW  tree bypass output.
- o_res_valid / i_res_ready  out/in  1  result handshake.
- o_res_id  out  1  requester ID of the result.
- o_res_mode  out  4  length mode of the result.
- o_res_cnt  out  3  number of valid sums: 1, 2 or 4.
- o_res_sum0..3  out  32 each  lane-packed sums.
- o_res_byp  out  64*DW  bypass vector of the result.
- o_res_err  out  1  result carried an illegal mode.
- o_err_seq  out  1  sticky sequencing error.

Behaviour:
- Reset (async, all state):
  - o_res_valid=0, o_res_* data=0, o_err_seq=0.
  - Tag FIFO empty; RR pointer = requester 0.
  - o_tree_en=1, o_tree_valid=0.
- Stall: o_tree_en = ~(o_res_valid & ~i_res_ready). This is combinational, so the tree freezes exactly when the output register is full and not draining.
- Arbitration, combinational, evaluated each cycle:
  - Only one requester valid: that requester is granted.
  - Both valid: the RR-pointer requester is granted.
  - o_reqK_ready = grantK & o_tree_en & ~fifo_full.
  - Accept = valid & ready. On accept the pointer moves to the other requester; otherwise it holds.
- Issue:
  - Tree inputs are muxed from the granted requester; o_tree_valid = accept.
  - {id, mode} pushed to the tag FIFO on accept.
  - Tree inputs are zero when no grant.
- Capture, on i_tree_valid_byp & o_tree_en:
  - Pop FIFO; load the output register; o_res_valid=1.
  - Simultaneous push and pop is legal; count is unchanged.
- Packing by popped mode:
  - mode 0: sum0 = sum64_0, cnt = 1.
  - mode 1: sum0..1 = sum32_0..1, cnt = 2.
  - mode 2: sum0..3 = sum16_0..3, cnt = 4.
  - Unused lanes are 0.
  - mode >= 3: all sums 0, cnt = 0, o_res_err = 1. The op is still accepted and still occupies one tree slot.
- Result draining:
  - o_res_valid clears on i_res_ready unless a new capture lands the same cycle.
  - A capture in the same cycle as the drain is a back-to-back transfer, with no bubble.
- Latency: accept at edge T gives o_res_valid at edge T+TREE_LAT+1, plus any stall cycles.
- Ordering: results return strictly in accept order.
- Sequencing errors, which set o_err_seq sticky until reset:
  - Tree valid arrives while the FIFO is empty; the result is dropped.
  - Popped mode differs from i_tree_mode_byp; the popped mode is used.
- fifo_full: blocks issue. It is unreachable when TAG_DEPTH >= TREE_LAT+1.
- Reset mid-operation: in-flight tags are discarded and the tree is reset in the same cycle. No stale result appears after reset release.

Optional Feature:
- Macro: ADD_TREE_SCHED_STATS_EN.
- Defined:
  - Adds outputs o_stat_iss0, o_stat_iss1 and o_stat_stall, 32 bits each.
  - o_stat_iss0 and o_stat_iss1 count accepts per requester.
  - o_stat_stall counts cycles with o_tree_en = 0.
  - All three saturate at all-ones and are cleared by reset.
- Undefined: these ports and counters are absent; functional behaviour is identical.

Decomposition:
- Package add_tree_pkg holds:
  - mode enum: LEN64=0, LEN32=1, LEN16=2;
  - DW, the vector width constant, TREE_LAT;
  - tag struct {id, mode}.
- Sub-module add_tree_tag_fifo: synchronous FIFO of the tag struct, depth TAG_DEPTH, with full/empty flags and same-cycle push/pop.

Test Plan:
- Req0 only, mode 0, all elements 0x0100 -> result 13 cycles after accept: sum0=0x00004000, cnt=1, id=0, err=0.
- Both requesters valid for 4 beats each:
  - grants alternate 0,1,0,1,…;
  - results carry ids 0,1,0,1,… in order;
  - one accept per cycle.
- Mode 1, elements 0–31 = 0x0100 and 32–63 = 0x0200, with i_res_ready=0 for 5 cycles mid-stream:
  - sum0=0x2000, sum1=0x4000, cnt=2;
  - o_tree_en low only while the output is full and not draining;
  - no result lost or duplicated.
- Mode 2, all elements -0x0100 -> sum0..3 = 0xFFFFF000, cnt=4. Then mode 3 -> err=1, sums 0, cnt=0.
- 5 ops in flight, i_rst_n pulsed low:
  - o_res_valid=0 immediately;
  - no result appears in the 20 cycles after release;
  - a new op then completes correctly with o_err_seq=0.
- ADD_TREE_SCHED_STATS_EN defined, 3 req0 + 2 req1 accepts with 4 stall cycles -> iss0=3, iss1=2, stall=4.
